// File: rtl/ddr_burst_responder.sv
// BRAM-backed stand-in for the DDR controller burst port of the cache interface.
// Optional DDR_RESP_STALL_EN inserts a bubble after every 4th beat.
module ddr_burst_responder #(
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int MEM_AW         = 10
) (
  input  logic                      mem_clk,
  input  logic                      rst,
  input  logic                      rd_burst_req,
  input  logic                      wr_burst_req,
  input  logic [9:0]                rd_burst_len,
  input  logic [9:0]                wr_burst_len,
  input  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  input  logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
  input  logic [DDR_DATA_WIDTH-1:0] wr_burst_data,
  output logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
  output logic                      rd_burst_data_valid,
  output logic                      wr_burst_data_req,
  output logic                      rd_burst_finish,
  output logic                      wr_burst_finish,
  output logic                      busy
);

`ifdef DDR_RESP_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_LAST, RD_ADDR, RD_DRAIN, FIN, GAP
  } state_t;

  state_t              state;
  logic [MEM_AW-1:0]   ptr;
  logic [9:0]          cnt;
  logic [1:0]          grp;
  logic                wr_cap;
  logic                rd_issue;
  logic                rd_en;

  logic [DDR_DATA_WIDTH-1:0] mem [2**MEM_AW];

  logic unused_addr;
  assign unused_addr = ^{rd_burst_addr[DDR_ADDR_WIDTH-1:MEM_AW],
                         wr_burst_addr[DDR_ADDR_WIDTH-1:MEM_AW]};

  assign busy  = (state != IDLE);
  assign rd_en = (state == RD_ADDR) && rd_issue;

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state               <= IDLE;
      ptr                 <= '0;
      cnt                 <= '0;
      grp                 <= '0;
      wr_cap              <= 1'b0;
      rd_issue            <= 1'b0;
      wr_burst_data_req   <= 1'b0;
      rd_burst_data_valid <= 1'b0;
      rd_burst_finish     <= 1'b0;
      wr_burst_finish     <= 1'b0;
    end else begin
      wr_cap              <= wr_burst_data_req;
      rd_burst_data_valid <= 1'b0;
      rd_burst_finish     <= 1'b0;
      wr_burst_finish     <= 1'b0;
      // write beats land one cycle after their request
      if (wr_cap)
        ptr <= ptr + 1'b1;
      unique case (state)
        IDLE: begin
          grp <= '0;
          if (wr_burst_req) begin
            ptr <= wr_burst_addr[MEM_AW-1:0];
            cnt <= wr_burst_len;
            if (wr_burst_len == '0) begin
              state           <= FIN;
              wr_burst_finish <= 1'b1;
            end else begin
              state             <= WR_REQ;
              wr_burst_data_req <= 1'b1;
            end
          end else if (rd_burst_req) begin
            ptr <= rd_burst_addr[MEM_AW-1:0];
            cnt <= rd_burst_len;
            if (rd_burst_len == '0) begin
              state           <= FIN;
              rd_burst_finish <= 1'b1;
            end else begin
              state    <= RD_ADDR;
              rd_issue <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (wr_burst_data_req) begin
            cnt <= cnt - 1'b1;
            grp <= grp + 1'b1;
            if (cnt == 10'd1) begin
              wr_burst_data_req <= 1'b0;
              state             <= WR_LAST;
            end else if (STALL && grp == 2'd3) begin
              wr_burst_data_req <= 1'b0;
            end
          end else begin
            wr_burst_data_req <= 1'b1;
          end
        end
        WR_LAST: begin
          state           <= FIN;
          wr_burst_finish <= 1'b1;
        end
        RD_ADDR: begin
          if (rd_issue) begin
            ptr                 <= ptr + 1'b1;
            cnt                 <= cnt - 1'b1;
            grp                 <= grp + 1'b1;
            rd_burst_data_valid <= 1'b1;
            if (cnt == 10'd1) begin
              rd_issue <= 1'b0;
              state    <= RD_DRAIN;
            end else if (STALL && grp == 2'd3) begin
              rd_issue <= 1'b0;
            end
          end else begin
            rd_issue <= 1'b1;
          end
        end
        RD_DRAIN: begin
          state           <= FIN;
          rd_burst_finish <= 1'b1;
        end
        FIN:     state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge mem_clk) begin
    if (wr_cap)
      mem[ptr] <= wr_burst_data;
  end

  always_ff @(posedge mem_clk) begin
    if (rst)
      rd_burst_data <= '0;
    else if (rd_en)
      rd_burst_data <= mem[ptr];
  end

endmodule

// File: tb/tb_ddr_burst_responder.sv
// Directed bench for ddr_burst_responder: write/read bursts, wrap,
// zero length, request priority and mid-burst reset.
module tb_ddr_burst_responder;

`ifdef DDR_RESP_STALL_EN
  localparam int STALL = 1;
`else
  localparam int STALL = 0;
`endif

  logic         mem_clk;
  logic         rst;
  logic         rd_burst_req;
  logic         wr_burst_req;
  logic [9:0]   rd_burst_len;
  logic [9:0]   wr_burst_len;
  logic [27:0]  rd_burst_addr;
  logic [27:0]  wr_burst_addr;
  logic [127:0] wr_burst_data;
  logic [127:0] rd_burst_data;
  logic         rd_burst_data_valid;
  logic         wr_burst_data_req;
  logic         rd_burst_finish;
  logic         wr_burst_finish;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] wbuf [16];
  logic [127:0] rbuf [16];

  ddr_burst_responder dut (
    .mem_clk             (mem_clk),
    .rst                 (rst),
    .rd_burst_req        (rd_burst_req),
    .wr_burst_req        (wr_burst_req),
    .rd_burst_len        (rd_burst_len),
    .wr_burst_len        (wr_burst_len),
    .rd_burst_addr       (rd_burst_addr),
    .wr_burst_addr       (wr_burst_addr),
    .wr_burst_data       (wr_burst_data),
    .rd_burst_data       (rd_burst_data),
    .rd_burst_data_valid (rd_burst_data_valid),
    .wr_burst_data_req   (wr_burst_data_req),
    .rd_burst_finish     (rd_burst_finish),
    .wr_burst_finish     (wr_burst_finish),
    .busy                (busy)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  // cycle (relative to request-seen cycle 0) in which beat k is issued
  function automatic int beat_cyc(input int k);
    return 1 + k + STALL * (k / 4);
  endfunction

  function automatic int exp_fin(input int len);
    return (len == 0) ? 1 : beat_cyc(len - 1) + 2;
  endfunction

  task automatic do_write(input logic [27:0] addr, input int len);
    int  nreq, idx, fin_c, nfin, nrdfin;
    bit  prev, done;
    nreq = 0; idx = 0; fin_c = -1; nfin = 0; nrdfin = 0;
    prev = 1'b0; done = 1'b0;
    wr_burst_req  = 1'b1;
    wr_burst_addr = addr;
    wr_burst_len  = 10'(len);
    for (int c = 1; c <= 80 && !done; c++) begin
      tick();
      wr_burst_data = '0;
      if (prev && idx < 16) begin
        wr_burst_data = wbuf[idx];
        idx++;
      end
      prev = wr_burst_data_req;
      if (wr_burst_data_req) begin
        chk("wr_req_cycle", 128'(c), 128'(beat_cyc(nreq)));
        nreq++;
      end
      if (wr_burst_finish) begin
        nfin++;
        if (fin_c < 0) fin_c = c;
      end
      if (rd_burst_finish) nrdfin++;
      if (fin_c >= 0 && c == fin_c + 1) wr_burst_req = 1'b0;
      if (fin_c >= 0 && c == fin_c + 2) begin
        chk("wr_busy_low", 128'(busy), 128'(0));
        done = 1'b1;
      end
    end
    chk("wr_done", 128'(done), 128'(1));
    chk("wr_nreq", 128'(nreq), 128'(len));
    chk("wr_nfin", 128'(nfin), 128'(1));
    chk("wr_fin_cycle", 128'(fin_c), 128'(exp_fin(len)));
    chk("wr_no_rd_fin", 128'(nrdfin), 128'(0));
  endtask

  task automatic do_read(input logic [27:0] addr, input int len);
    int  nv, fin_c, nfin, nwreq;
    bit  done;
    nv = 0; fin_c = -1; nfin = 0; nwreq = 0; done = 1'b0;
    rd_burst_req  = 1'b1;
    rd_burst_addr = addr;
    rd_burst_len  = 10'(len);
    for (int c = 1; c <= 80 && !done; c++) begin
      tick();
      if (rd_burst_data_valid) begin
        chk("rd_valid_cycle", 128'(c), 128'(beat_cyc(nv) + 1));
        if (nv < 16) chk("rd_data", rd_burst_data, rbuf[nv]);
        nv++;
      end
      if (wr_burst_data_req) nwreq++;
      if (rd_burst_finish) begin
        nfin++;
        if (fin_c < 0) begin
          fin_c = c;
          if (len > 0) chk("rd_data_hold", rd_burst_data, rbuf[len-1]);
        end
      end
      if (fin_c >= 0 && c == fin_c + 1) rd_burst_req = 1'b0;
      if (fin_c >= 0 && c == fin_c + 2) begin
        chk("rd_busy_low", 128'(busy), 128'(0));
        done = 1'b1;
      end
    end
    chk("rd_done", 128'(done), 128'(1));
    chk("rd_nvalid", 128'(nv), 128'(len));
    chk("rd_nfin", 128'(nfin), 128'(1));
    chk("rd_fin_cycle", 128'(fin_c), 128'(exp_fin(len)));
    chk("rd_no_wr_req", 128'(nwreq), 128'(0));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_data_req"}, 128'(wr_burst_data_req), 128'(0));
    chk({tag, "_valid"}, 128'(rd_burst_data_valid), 128'(0));
    chk({tag, "_rd_fin"}, 128'(rd_burst_finish), 128'(0));
    chk({tag, "_wr_fin"}, 128'(wr_burst_finish), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_rd_data"}, rd_burst_data, 128'(0));
  endtask

  initial begin
    int  nfin;
    bit  prev;
    int  idx;
    rst           = 1'b1;
    rd_burst_req  = 1'b0;
    wr_burst_req  = 1'b0;
    rd_burst_len  = '0;
    wr_burst_len  = '0;
    rd_burst_addr = '0;
    wr_burst_addr = '0;
    wr_burst_data = '0;
    tick();
    tick();
    chk_quiet("reset");
    rst = 1'b0;

    // basic write then read
    for (int i = 0; i < 4; i++) wbuf[i] = 128'(8'hA0 + i);
    for (int i = 0; i < 4; i++) rbuf[i] = wbuf[i];
    do_write(28'h0008000, 4);
    do_read(28'h0008000, 4);

    // wrap at the top of the array
    for (int i = 0; i < 3; i++) wbuf[i] = 128'(i + 1);
    for (int i = 0; i < 3; i++) rbuf[i] = wbuf[i];
    do_write(28'h00003FE, 3);
    do_read(28'h00003FE, 3);
    rbuf[0] = 128'(3);
    rbuf[1] = 128'hA1;
    do_read(28'h0000000, 2);
    rbuf[0] = 128'hA1;
    do_read(28'hABC0001, 1);

    // zero length
    do_read(28'h0000010, 0);
    do_write(28'h0000010, 0);

    // simultaneous requests: write first, read sees new data
    wbuf[0] = 128'hC0; wbuf[1] = 128'hC1;
    rbuf[0] = 128'hC0; rbuf[1] = 128'hC1;
    rd_burst_req  = 1'b1;
    rd_burst_addr = 28'h0000200;
    rd_burst_len  = 10'd2;
    do_write(28'h0000200, 2);
    do_read(28'h0000200, 2);

    // nine beats (bubbles after beats 4 and 8 when stalling)
    for (int i = 0; i < 9; i++) wbuf[i] = {64'hDEAD_0000_0000_0000, 64'(i)};
    for (int i = 0; i < 9; i++) rbuf[i] = wbuf[i];
    do_write(28'h0000300, 9);
    do_read(28'h0000300, 9);

    // reset during the 3rd data cycle of a len=8 write
    for (int i = 0; i < 8; i++) wbuf[i] = 128'(8'hB0 + i);
    nfin = 0; prev = 1'b0; idx = 0;
    wr_burst_req  = 1'b1;
    wr_burst_addr = 28'h0000100;
    wr_burst_len  = 10'd8;
    for (int c = 1; c <= 4; c++) begin
      tick();
      wr_burst_data = '0;
      if (prev) begin
        wr_burst_data = wbuf[idx];
        idx++;
      end
      prev = wr_burst_data_req;
      if (wr_burst_finish) nfin++;
      if (c == 4) rst = 1'b1;
    end
    tick();
    rst          = 1'b0;
    wr_burst_req = 1'b0;
    chk_quiet("midrst");
    chk("midrst_no_fin", 128'(nfin), 128'(0));
    rbuf[0] = 128'hB0; rbuf[1] = 128'hB1;
    do_read(28'h0000100, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
